rotary_decoder: RTL and testbench

ROTARY_DECODER -- requirements
Module: rotary_decoder

---
 rtl/rotary_decoder.sv | 140 ++++++++++++++
 tb/tb_rotary_decoder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rotary_decoder.sv
// Quadrature rotary-encoder front end: synchronizes and debounces A/B, tracks
// the quarter-step accumulator and emits one event per full detent.
module rotary_decoder #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int COUNTER_WIDTH   = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] rotary,
    output logic       rotation_event,
    output logic       rotation_left,
    output logic [7:0] position,
    output logic       error
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_LAST = COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);

    logic [1:0]               sync_1;
    logic [1:0]               sync_2;
    logic [1:0]               filt;
    logic [1:0]               prev;
    logic [COUNTER_WIDTH-1:0] cnt [2];
    logic signed [2:0]        acc;

    logic signed [2:0]        acc_n;
    logic signed [3:0]        step;
    logic signed [3:0]        sum;
    logic [1:0]               delta;
    logic                     event_n;
    logic                     left_n;
    logic                     error_n;
    logic [7:0]               position_n;

    // Gray phase index along the CW direction: 11 -> 10 -> 00 -> 01.
    function automatic logic [1:0] phase_idx(input logic [1:0] s);
        case (s)
            2'b11:   phase_idx = 2'd0;
            2'b10:   phase_idx = 2'd1;
            2'b00:   phase_idx = 2'd2;
            default: phase_idx = 2'd3;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_1 <= 2'b11;
            sync_2 <= 2'b11;
        end else begin
            sync_1 <= rotary;
            sync_2 <= sync_1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            filt <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    filt[i] <= sync_2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end
            end
        end
    end

    always_comb begin
        delta      = phase_idx(filt) - phase_idx(prev);
        step       = 4'sd0;
        acc_n      = acc;
        event_n    = 1'b0;
        left_n     = rotation_left;
        error_n    = 1'b0;
        position_n = position;

        case (delta)
            2'd1:    step = 4'sd1;
            2'd3:    step = -4'sd1;
            default: step = 4'sd0;
        endcase

        sum = {acc[2], acc} + step;
        if (sum > 4'sd4) begin
            sum = 4'sd4;
        end else if (sum < -4'sd4) begin
            sum = -4'sd4;
        end

        if (delta == 2'd2) begin
            // Both bits moved in one cycle: direction is unknowable.
            error_n = 1'b1;
            acc_n   = 3'sd0;
        end else if (delta != 2'd0 && filt == 2'b11) begin
            acc_n = 3'sd0;
            if (sum == 4'sd4) begin
                event_n    = 1'b1;
                left_n     = 1'b0;
                position_n = position + 8'd1;
            end else if (sum == -4'sd4) begin
                event_n    = 1'b1;
                left_n     = 1'b1;
                position_n = position - 8'd1;
            end
        end else if (sum > 4'sd3) begin
            // Unreachable without passing through 11; keeps the store in range.
            acc_n = 3'sd3;
        end else begin
            acc_n = sum[2:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            prev           <= 2'b11;
            acc            <= 3'sd0;
            position       <= 8'd0;
            rotation_event <= 1'b0;
            rotation_left  <= 1'b0;
            error          <= 1'b0;
        end else begin
            prev           <= filt;
            acc            <= acc_n;
            rotation_event <= event_n;
            error          <= error_n;
            if (event_n) begin
                rotation_left <= left_n;
                position      <= position_n;
            end
        end
    end

endmodule

// File: tb/tb_rotary_decoder.sv
// Directed bench for rotary_decoder with DEBOUNCE_CYCLES=4: detents in both
// directions, bounce, reversal, illegal jumps and resets mid-rotation.
module tb_rotary_decoder;

    logic       clock;
    logic       reset;
    logic [1:0] rotary;
    logic       rotation_event;
    logic       rotation_left;
    logic [7:0] position;
    logic       error;

    int n_checks = 0;
    int n_fail   = 0;

    int ev_cnt    = 0;
    int err_cnt   = 0;
    int overlap   = 0;
    int last_left = 0;
    int pos_at_ev = -1;

    int ev0;
    int err0;
    int lat;

    rotary_decoder #(
        .DEBOUNCE_CYCLES(4),
        .COUNTER_WIDTH  (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .rotary        (rotary),
        .rotation_event(rotation_event),
        .rotation_left (rotation_left),
        .position      (position),
        .error         (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset) begin
            if (rotation_event) begin
                ev_cnt++;
                last_left = int'(rotation_left);
                pos_at_ev = int'(position);
            end
            if (error) err_cnt++;
            if (rotation_event && error) overlap++;
        end
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_phase(input logic [1:0] v, input int n);
        rotary = v;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic snap();
        ev0  = ev_cnt;
        err0 = err_cnt;
    endtask

    initial begin
        reset  = 1'b0;
        rotary = 2'b11;
        @(posedge clock);
        #1;
        do_reset(3);
        check_eq("rst_position", int'(position), 0);
        check_eq("rst_event", int'(rotation_event), 0);
        check_eq("rst_error", int'(error), 0);
        check_eq("rst_left", int'(rotation_left), 0);

        // clean CW detent, measuring latency of the final edge
        snap();
        do_phase(2'b10, 20);
        do_phase(2'b00, 20);
        do_phase(2'b01, 20);
        rotary = 2'b11;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock);
            #1;
            if (rotation_event && lat == 0) lat = i;
        end
        check_eq("cw_events", ev_cnt - ev0, 1);
        check_eq("cw_errors", err_cnt - err0, 0);
        check_eq("cw_position", int'(position), 1);
        check_eq("cw_left", last_left, 0);
        check_eq("cw_pos_at_event", pos_at_ev, 1);
        check_eq("cw_latency", lat, 7);

        // bounce on A shorter than the debounce window
        snap();
        do_phase(2'b10, 3);
        do_phase(2'b11, 3);
        do_phase(2'b10, 3);
        do_phase(2'b11, 20);
        check_eq("bounce_events", ev_cnt - ev0, 0);
        check_eq("bounce_errors", err_cnt - err0, 0);
        check_eq("bounce_position", int'(position), 1);
        check_eq("bounce_left_held", int'(rotation_left), 0);

        // reversal mid-detent, then a CCW detent
        snap();
        do_phase(2'b10, 20);
        do_phase(2'b00, 20);
        do_phase(2'b10, 20);
        do_phase(2'b11, 20);
        check_eq("rev_events", ev_cnt - ev0, 0);
        check_eq("rev_errors", err_cnt - err0, 0);
        check_eq("rev_position", int'(position), 1);
        snap();
        do_phase(2'b01, 20);
        do_phase(2'b00, 20);
        do_phase(2'b10, 20);
        do_phase(2'b11, 20);
        check_eq("ccw_events", ev_cnt - ev0, 1);
        check_eq("ccw_position", int'(position), 0);
        check_eq("ccw_left", int'(rotation_left), 1);

        // CCW detent from reset wraps 0 -> 255
        do_reset(2);
        snap();
        do_phase(2'b01, 20);
        do_phase(2'b00, 20);
        do_phase(2'b10, 20);
        do_phase(2'b11, 20);
        check_eq("wrap_ccw_events", ev_cnt - ev0, 1);
        check_eq("wrap_ccw_position", int'(position), 255);
        check_eq("wrap_ccw_left", last_left, 1);

        // illegal 11 -> 00 jump, then recover and wrap 255 -> 0 on a CW detent
        snap();
        do_phase(2'b00, 20);
        check_eq("illegal_errors", err_cnt - err0, 1);
        check_eq("illegal_events", ev_cnt - ev0, 0);
        do_phase(2'b01, 20);
        do_phase(2'b11, 20);
        check_eq("partial_events", ev_cnt - ev0, 0);
        do_phase(2'b10, 20);
        do_phase(2'b00, 20);
        do_phase(2'b01, 20);
        do_phase(2'b11, 20);
        check_eq("wrap_cw_events", ev_cnt - ev0, 1);
        check_eq("wrap_cw_position", int'(position), 0);
        check_eq("wrap_cw_left", int'(rotation_left), 0);
        check_eq("wrap_cw_errors", err_cnt - err0, 1);

        // reset mid-detent; release with inputs at 00 flags an error
        do_reset(2);
        snap();
        do_phase(2'b10, 20);
        do_phase(2'b00, 20);
        do_reset(2);
        do_phase(2'b00, 20);
        do_phase(2'b01, 20);
        do_phase(2'b11, 20);
        check_eq("midrst_events", ev_cnt - ev0, 0);
        check_eq("midrst_position", int'(position), 0);
        check_eq("midrst_errors", err_cnt - err0, 1);

        check_eq("event_error_overlap", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
